fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 34 +++
 rtl/fetch_queue.sv | 55 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// queue entry layout and PC helpers.
package fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 64;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
        return {pc[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch bus: instruction-cache handshake, execute redirect and decode
// hand-off. The fetch unit is the master; cache/execute/decode form the slave.
interface fetch_if;
    import fetch_pkg::*;

    logic                   icache_read_enable;
    logic [ADDR_WIDTH-1:0]  icache_address;
    logic [INSTR_WIDTH-1:0] icache_data;
    logic                   icache_send_enable;
    logic                   icache_jump_reset;

    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;

    logic                   dec_valid;
    logic                   dec_ready;
    logic [INSTR_WIDTH-1:0] dec_instr;
    logic [ADDR_WIDTH-1:0]  dec_pc;

    modport master (
        output icache_read_enable, icache_address, icache_jump_reset,
        output dec_valid, dec_instr, dec_pc,
        input  icache_data, icache_send_enable,
        input  redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  icache_read_enable, icache_address, icache_jump_reset,
        input  dec_valid, dec_instr, dec_pc,
        output icache_data, icache_send_enable,
        output redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO between fetch and decode. A flush empties it in one cycle
// and takes priority over a same-cycle push or pop.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    output logic         o_valid,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    localparam int DEPTH = 2;

    fetch_entry_t r_mem [DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_pop;

    assign o_valid = (r_count != 2'd0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = i_pop && o_valid;

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is reset as well so the decode head reads zero out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding four-phase cache request feeding a
// two-entry decode queue. Define FETCH_PERF_CNT_EN to build the perf counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    fetch_if.master     bus,
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [ADDR_WIDTH-1:0] w_address_nxt;
    logic                  r_read_enable;
    logic                  w_read_enable_nxt;
    logic                  r_jump_reset;
    logic                  r_squash;
    logic                  w_capture;
    logic                  w_push;
    logic                  w_can_issue;
    logic [1:0]            w_count;
    logic                  w_dec_valid;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;

    assign w_capture    = (r_state == ST_REQ) && bus.icache_send_enable;
    assign w_push       = w_capture && !r_squash && !bus.redirect_valid;
    // A lingering send_enable (e.g. after a reset mid-handshake) also blocks a new request.
    assign w_can_issue  = (w_count < 2'd2) && !bus.redirect_valid && !bus.icache_send_enable;
    assign w_push_entry = '{pc: r_address, instr: bus.icache_data};

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_can_issue)             w_state_nxt = ST_REQ;
            ST_REQ:   if (bus.icache_send_enable)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!bus.icache_send_enable) w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_read_enable_nxt = (w_state_nxt == ST_REQ);
        w_address_nxt     = r_address;
        if (r_state == ST_IDLE && w_state_nxt == ST_REQ) w_address_nxt = r_pc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_read_enable <= 1'b0;
            r_address     <= '0;
            r_jump_reset  <= 1'b0;
        end else begin
            r_read_enable <= w_read_enable_nxt;
            r_address     <= w_address_nxt;
            r_jump_reset  <= bus.redirect_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                          r_pc <= align_pc(RESET_PC);
        else if (bus.redirect_valid)        r_pc <= align_pc(bus.redirect_pc);
        else if (w_capture && !r_squash)    r_pc <= r_pc + PC_STEP;
    end

    // Squash marks the in-flight word as stale; it lives until the handshake closes.
    always_ff @(posedge clock) begin
        if (reset)
            r_squash <= 1'b0;
        else if (r_state == ST_DRAIN && !bus.icache_send_enable)
            r_squash <= 1'b0;
        else if (r_state == ST_REQ && !bus.icache_send_enable && bus.redirect_valid)
            r_squash <= 1'b1;
    end

    fetch_queue u_queue (
        .clock        (clock),
        .reset        (reset),
        .i_flush      (bus.redirect_valid),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (bus.dec_ready),
        .o_valid      (w_dec_valid),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign bus.icache_read_enable = r_read_enable;
    assign bus.icache_address     = r_address;
    assign bus.icache_jump_reset  = r_jump_reset;
    assign bus.dec_valid          = w_dec_valid;
    assign bus.dec_instr          = w_head.instr;
    assign bus.dec_pc             = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_push && r_fetch_count != '1)
                r_fetch_count <= r_fetch_count + 32'd1;
            if (r_state == ST_REQ && !bus.icache_send_enable && r_stall_count != '1)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign perf_fetch_count = r_fetch_count;
    assign perf_stall_count = r_stall_count;
`else
    assign perf_fetch_count = '0;
    assign perf_stall_count = '0;
`endif

endmodule
